// File: rtl/uart_tx_fifo_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_cfg
//
// Purpose:
//   UART transmitter with a small input FIFO and per-frame configuration.
//   Each frame carries a start bit, 5..DATA_WIDTH data bits (LSB first), an
//   optional even/odd parity bit and one or two stop bits. Queued words go
//   out back-to-back with no idle gap between frames.
//
// Parameters:
//   CLOCKS_PER_PULSE  clk cycles per serial bit (>= 2)
//   DATA_WIDTH        maximum data bits per frame (5..9)
//   FIFO_DEPTH        input FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   data_in        word to transmit, LSB first
//   data_en        write strobe, accepted while data_ready=1
//   data_ready     FIFO not full (registered)
//   cfg_data_bits  data bits per frame, clamped to [5, DATA_WIDTH]
//   cfg_parity     00 none, 01 even, 10 odd, 11 none
//   cfg_stop2      0 = one stop bit, 1 = two stop bits
//   tx             serial line, idle high, driven from a register
//   tx_busy        high while any frame bit is on the line
//   fifo_count     current FIFO occupancy
//   overflow       one-cycle pulse when a write hits a full FIFO
// -----------------------------------------------------------------------------
module uart_tx_fifo_cfg #(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_en,
  output logic                          data_ready,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(CLOCKS_PER_PULSE);
  localparam int IDXW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0]   BIT_LAST   = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);
  localparam logic [3:0]      MAX_BITS   = 4'(DATA_WIDTH);
  localparam logic [3:0]      MIN_BITS   = 4'd5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wrPtr_q, rdPtr_q;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  ready_q;
  logic                  overflow_q;
  logic                  fifoFull, fifoEmpty;
  logic                  push, pop;

  // Frame head preparation
  logic [3:0]            clampedBits;
  logic [DATA_WIDTH-1:0] maskedHead;
  logic                  headParity;

  // Transmit FSM state
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IDXW-1:0]       bitIdx_q, bitIdx_d;
  logic [IDXW-1:0]       lastIdx_q, lastIdx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parityEn_q, parityEn_d;
  logic                  parityBit_q, parityBit_d;
  logic                  stop2_q, stop2_d;
  logic                  stopIdx_q, stopIdx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bitEnd;
  logic                  startFrame;

  assign fifoFull  = (count_q == FULL_COUNT);
  assign fifoEmpty = (count_q == '0);
  // A write while full is dropped even if the FSM pops in the same cycle.
  assign push      = data_en && !fifoFull;
  assign bitEnd    = (cnt_q == BIT_LAST);

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and the registered status flags. Pointers are
  // exactly log2(depth) wide so they wrap on their own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q    <= count_d;
      ready_q    <= (count_d != FULL_COUNT);
      overflow_q <= data_en && fifoFull;
    end
  end

  // Storage array carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= data_in;
  end

  // Clamp the requested width, drop data bits above it and precompute the
  // even parity of what will actually be sent, so a popped word is ready to
  // shift out without further per-bit bookkeeping.
  always_comb begin
    clampedBits = cfg_data_bits;
    if (cfg_data_bits < MIN_BITS)      clampedBits = MIN_BITS;
    else if (cfg_data_bits > MAX_BITS) clampedBits = MAX_BITS;
    maskedHead = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      maskedHead[i] = mem[rdPtr_q][i] & (4'(i) < clampedBits);
    end
    headParity = ^maskedHead;
  end

  // Next-state logic. Each state holds its line level for one bit time
  // (cnt wraps at BIT_LAST); tx_d is the level for the coming cycle, so the
  // line register changes on the same edge the state does. Loading a new
  // frame is shared between IDLE and the end of STOP, which is what lets
  // queued frames follow each other without an idle cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    bitIdx_d    = bitIdx_q;
    lastIdx_d   = lastIdx_q;
    shift_d     = shift_q;
    parityEn_d  = parityEn_q;
    parityBit_d = parityBit_q;
    stop2_d     = stop2_q;
    stopIdx_d   = stopIdx_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    startFrame  = 1'b0;
    pop         = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bitEnd ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifoEmpty) startFrame = 1'b1;
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitIdx_d = '0;
          tx_d     = shift_q[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx_q == lastIdx_q) begin
            if (parityEn_q) begin
              state_d = PARITY;
              tx_d    = parityBit_q;
            end else begin
              state_d   = STOP;
              stopIdx_d = 1'b0;
              tx_d      = 1'b1;
            end
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
            shift_d  = shift_q >> 1;
            tx_d     = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          state_d   = STOP;
          stopIdx_d = 1'b0;
          tx_d      = 1'b1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (stop2_q && !stopIdx_q) begin
            stopIdx_d = 1'b1;
          end else if (!fifoEmpty) begin
            startFrame = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Config is captured here only, so mid-frame changes wait for the next pop.
    if (startFrame) begin
      pop         = 1'b1;
      state_d     = START;
      cnt_d       = '0;
      tx_d        = 1'b0;
      busy_d      = 1'b1;
      shift_d     = maskedHead;
      lastIdx_d   = IDXW'(clampedBits - 4'd1);
      parityEn_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      parityBit_d = headParity ^ (cfg_parity == 2'b10);
      stop2_d     = cfg_stop2;
      stopIdx_d   = 1'b0;
    end
  end

  // FSM and line registers; reset aborts any frame and idles the line at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      lastIdx_q   <= '0;
      shift_q     <= '0;
      parityEn_q  <= 1'b0;
      parityBit_q <= 1'b0;
      stop2_q     <= 1'b0;
      stopIdx_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      lastIdx_q   <= lastIdx_d;
      shift_q     <= shift_d;
      parityEn_q  <= parityEn_d;
      parityBit_q <= parityBit_d;
      stop2_q     <= stop2_d;
      stopIdx_q   <= stopIdx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign data_ready = ready_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_cfg
//
// Purpose:
//   Self-checking bench for uart_tx_fifo_cfg. A reference model keeps the
//   FIFO as a queue of words and the line as a queue of per-cycle levels
//   built from whole frames; every cycle the DUT outputs are compared with
//   it. Fixed frame vectors and hand-written multi-cycle sequences add
//   checks against constant expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_cfg;

  localparam int CPP   = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] data_in;
  logic          data_en;
  logic          data_ready;
  logic [3:0]    cfg_data_bits;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;
  logic          tx;
  logic          tx_busy;
  logic [2:0]    fifo_count;
  logic          overflow;

  int nVectors    = 0;
  int nMiscompares = 0;

  // Reference model state
  logic [DW-1:0] refQueue[$];
  logic          refLine[$];
  logic          refOverflow;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    bits;
    logic [1:0]    parity;
    logic          stop2;
    int            slots;
    logic [15:0]   frame;
  } vec_t;

  vec_t vecs[7];

  uart_tx_fifo_cfg #(
    .CLOCKS_PER_PULSE(CPP),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .data_in(data_in),
    .data_en(data_en),
    .data_ready(data_ready),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2),
    .tx(tx),
    .tx_busy(tx_busy),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Hard stop in case anything stalls
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic compare(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    refQueue.delete();
    refLine.delete();
    refOverflow = 1'b0;
  endfunction

  // Append a whole frame, one level per clock cycle, using the config
  // currently on the cfg inputs.
  function automatic void modelFrame(input logic [DW-1:0] word);
    int   n;
    logic par;
    n   = int'(cfg_data_bits);
    if (n < 5)  n = 5;
    if (n > DW) n = DW;
    par = 1'b0;
    repeat (CPP) refLine.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      par = par ^ word[i];
      repeat (CPP) refLine.push_back(word[i]);
    end
    if (cfg_parity == 2'b01) repeat (CPP) refLine.push_back(par);
    if (cfg_parity == 2'b10) repeat (CPP) refLine.push_back(!par);
    repeat (CPP * (cfg_stop2 ? 2 : 1)) refLine.push_back(1'b1);
  endfunction

  // One clock edge of the model: the cycle that just ended is retired, a new
  // frame starts when the line has nothing left and a word is waiting, and
  // then the write is accepted or dropped based on fullness before the edge.
  function automatic void modelStep();
    bit wasFull;
    if (!rstn) begin
      modelReset();
      return;
    end
    wasFull = (refQueue.size() == DEPTH);
    if (refLine.size() > 0) void'(refLine.pop_front());
    if (refLine.size() == 0 && refQueue.size() > 0) modelFrame(refQueue.pop_front());
    refOverflow = data_en && wasFull;
    if (data_en && !wasFull) refQueue.push_back(data_in);
  endfunction

  task automatic checkOutput();
    logic expTx;
    expTx = (refLine.size() > 0) ? refLine[0] : 1'b1;
    compare("tx", 32'(tx), 32'(expTx));
    compare("tx_busy", 32'(tx_busy), 32'(refLine.size() > 0));
    compare("fifo_count", 32'(fifo_count), 32'(refQueue.size()));
    compare("data_ready", 32'(data_ready), 32'(refQueue.size() < DEPTH));
    compare("overflow", 32'(overflow), 32'(refOverflow));
  endtask

  task automatic applyStimulus(input logic en, input logic [DW-1:0] d);
    data_en = en;
    data_in = d;
  endtask

  task automatic setCfg(input logic [3:0] bits, input logic [1:0] par, input logic stop2);
    cfg_data_bits = bits;
    cfg_parity    = par;
    cfg_stop2     = stop2;
  endtask

  // Advance one clock, update the model on the edge, check 1 time unit later.
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    int busyCount;
    int runLen;
    bit seenBusy;
    bit runDone;

    vecs[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, 10, 16'({1'b1, 8'hA5, 1'b0})};
    vecs[1] = '{8'h35, 4'd7,  2'b01, 1'b1, 11, 16'({2'b11, 1'b0, 7'h35, 1'b0})};
    vecs[2] = '{8'hFF, 4'd8,  2'b10, 1'b0, 11, 16'({1'b1, 1'b1, 8'hFF, 1'b0})};
    vecs[3] = '{8'hFE, 4'd8,  2'b10, 1'b0, 11, 16'({1'b1, 1'b0, 8'hFE, 1'b0})};
    vecs[4] = '{8'hF3, 4'd3,  2'b00, 1'b0, 7,  16'({1'b1, 5'h13, 1'b0})};
    vecs[5] = '{8'h5A, 4'd15, 2'b10, 1'b1, 12, 16'({2'b11, 1'b1, 8'h5A, 1'b0})};
    vecs[6] = '{8'h2C, 4'd6,  2'b11, 1'b0, 8,  16'({1'b1, 6'h2C, 1'b0})};

    // Reset state
    rstn = 1'b0;
    applyStimulus(1'b0, '0);
    setCfg(4'd8, 2'b00, 1'b0);
    modelReset();
    #12;
    compare("reset_tx", 32'(tx), 32'd1);
    compare("reset_busy", 32'(tx_busy), 32'd0);
    compare("reset_ready", 32'(data_ready), 32'd1);
    compare("reset_count", 32'(fifo_count), 32'd0);
    compare("reset_overflow", 32'(overflow), 32'd0);
    #10;
    rstn = 1'b1;
    tick();

    // Single frames from the vector table
    $display("[TB] frame vectors");
    for (int v = 0; v < 7; v++) begin
      setCfg(vecs[v].bits, vecs[v].parity, vecs[v].stop2);
      applyStimulus(1'b1, vecs[v].data);
      tick();
      applyStimulus(1'b0, '0);
      busyCount = 0;
      for (int t = 0; t < 13 * CPP + 16; t++) begin
        tick();
        if (tx_busy) busyCount++;
        if (t == 0) begin
          compare("start_latency_busy", 32'(tx_busy), 32'd1);
          compare("start_latency_tx", 32'(tx), 32'd0);
        end
        if (t < vecs[v].slots * CPP && (t % CPP) == CPP / 2)
          compare("frame_slot", 32'(tx), 32'(vecs[v].frame[t / CPP]));
      end
      compare("frame_length", 32'(busyCount), 32'(vecs[v].slots * CPP));
    end

    // Burst of five writes during a frame: fill, overflow, back-to-back frames
    $display("[TB] burst and overflow");
    setCfg(4'd8, 2'b00, 1'b0);
    runLen   = 0;
    seenBusy = 1'b0;
    runDone  = 1'b0;
    applyStimulus(1'b1, 8'h11);
    tick();
    applyStimulus(1'b1, 8'h22); tick(); runLen++;
    applyStimulus(1'b1, 8'h33); tick(); runLen++;
    applyStimulus(1'b1, 8'h44); tick(); runLen++;
    applyStimulus(1'b1, 8'h55); tick(); runLen++;
    compare("burst_ready_full", 32'(data_ready), 32'd0);
    compare("burst_count_full", 32'(fifo_count), 32'd4);
    applyStimulus(1'b1, 8'h66); tick(); runLen++;
    compare("burst_overflow_pulse", 32'(overflow), 32'd1);
    compare("burst_count_kept", 32'(fifo_count), 32'd4);
    applyStimulus(1'b0, '0); tick(); runLen++;
    compare("burst_overflow_end", 32'(overflow), 32'd0);
    seenBusy = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      tick();
      if (!runDone) begin
        if (tx_busy) runLen++;
        else runDone = 1'b1;
      end
    end
    compare("burst_busy_run", 32'(runLen), 32'(5 * 10 * CPP));

    // Asynchronous reset in the middle of a data bit with two words queued
    $display("[TB] async reset mid-frame");
    applyStimulus(1'b1, 8'h81); tick();
    applyStimulus(1'b1, 8'h82); tick();
    applyStimulus(1'b1, 8'h83); tick();
    applyStimulus(1'b0, '0);
    for (int t = 2; t <= 50; t++) tick();
    compare("pre_reset_count", 32'(fifo_count), 32'd2);
    compare("pre_reset_busy", 32'(tx_busy), 32'd1);
    #2;
    rstn = 1'b0;
    modelReset();
    #1;
    compare("async_reset_tx", 32'(tx), 32'd1);
    compare("async_reset_busy", 32'(tx_busy), 32'd0);
    compare("async_reset_count", 32'(fifo_count), 32'd0);
    compare("async_reset_ready", 32'(data_ready), 32'd1);
    repeat (3) tick();
    #2;
    rstn = 1'b1;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (t % 40 == 0) compare("post_reset_idle_tx", 32'(tx), 32'd1);
    end

    // Parity enabled mid-frame: affects only the following frames
    $display("[TB] config change mid-frame");
    setCfg(4'd8, 2'b00, 1'b0);
    applyStimulus(1'b1, 8'h03); tick();
    applyStimulus(1'b1, 8'h03); tick();
    applyStimulus(1'b1, 8'h0F); tick();
    applyStimulus(1'b0, '0);
    for (int t = 2; t <= 560; t++) begin
      if (t == 20) cfg_parity = 2'b01;
      tick();
      if (t == 152) compare("cfgchg_first_stop", 32'(tx), 32'd1);
      if (t == 312) compare("cfgchg_second_parity", 32'(tx), 32'd0);
      if (t == 328) compare("cfgchg_second_stop", 32'(tx), 32'd1);
      if (t == 336) compare("cfgchg_third_start", 32'(tx), 32'd0);
    end

    // Randomized traffic and config against the reference model
    $display("[TB] random traffic");
    for (int t = 0; t < 7000; t++) begin
      if ($urandom_range(0, 49) == 0)
        setCfg(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (t < 5000)
        applyStimulus($urandom_range(0, 5) == 0, DW'($urandom));
      else
        applyStimulus($urandom_range(0, 1) == 0, DW'($urandom));
      tick();
    end
    applyStimulus(1'b0, '0);
    for (int t = 0; t < 1200; t++) tick();
    compare("final_idle_busy", 32'(tx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter with a small input FIFO and runtime frame configuration. It supports a variable data-bit count, none/even/odd parity and 1 or 2 stop bits. Frames are sent back-to-back from the FIFO. It sits between a byte producer (CPU/bus or test-pattern logic) and the FPGA TX pin, and replaces the fixed 8N1 single-buffer transmitter.

Parameters:
CLOCKS_PER_PULSE, 16, clk cycles per serial bit; must be >= 2.
DATA_WIDTH, 8, maximum data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  system clock; all logic on rising edge.
rstn  in  1  asynchronous active-low reset.
data_in  in  DATA_WIDTH  word to transmit, LSB first.
data_en  in  1  write strobe; pushes data_in when data_ready=1.
data_ready  out  1  FIFO not full (registered).
cfg_data_bits  in  4  data bits per frame.
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
cfg_stop2  in  1  0 = 1 stop bit, 1 = 2 stop bits.
tx  out  1  serial line; idle high.
tx_busy  out  1  high while any frame bit is being driven.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  out  1  one-cycle pulse when data_en is asserted while full; word dropped.

Behaviour:
- Reset (async, rstn=0):
  - Outputs: tx=1, tx_busy=0, data_ready=1, fifo_count=0, overflow=0.
  - FIFO emptied and FSM forced to IDLE; any in-flight frame is aborted immediately.
  - Operation resumes on the first clk edge after rstn deasserts.
- FIFO:
  - Push on edge where data_en=1 and data_ready=1.
  - Pop only on frame start.
  - A push while full is rejected even if a pop occurs in the same cycle; overflow pulses and the count is unchanged.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, tx_busy=0. On an edge with FIFO non-empty: pop, latch word and config, go to START.
  - START: tx=0 for CLOCKS_PER_PULSE cycles, then go to DATA.
  - DATA: drive latched bits LSB first, each for CLOCKS_PER_PULSE cycles. After n bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: even mode drives the XOR of the n sent bits; odd mode drives its inverse. Lasts one bit time.
  - STOP: tx=1 for 1 or 2 bit times. At the end, if the FIFO is non-empty, pop and go directly to START (no idle cycle; tx_busy stays 1); else go to IDLE.
- Latency: word pushed into an empty FIFO at edge E0 while IDLE → FSM pops and enters START at E1; tx=0 and tx_busy=1 from E1. fifo_count reads 1 for one cycle.
- Frame length: (1 + n + p + s) × CLOCKS_PER_PULSE cycles, where p ∈ {0,1} and s ∈ {1,2}.
- Config clamping: n = cfg_data_bits clamped to [5, DATA_WIDTH]; data_in bits above n are ignored.
- Config timing: cfg_* is sampled only at pop; changes mid-frame take effect on the next frame.
- Counters: bit-time counter runs 0..CLOCKS_PER_PULSE-1 and wraps; bit index counter is sized for DATA_WIDTH.
- tx is driven from a register (glitch-free).
- tx_busy: registered, high from START entry through the last stop-bit cycle.

Test Plan:
1. Reset, defaults, cfg 8N1, push 0xA5 → tx low 16 cycles starting one cycle after the push, then data 1,0,1,0,0,1,0,1, then stop high 16 cycles; tx_busy high exactly 160 cycles.
2. cfg_data_bits=7, even parity, cfg_stop2=1, push 0x35 → data 1,0,1,0,1,1,0, parity 0, two stop bits; frame 176 cycles.
3. cfg 8 bits, odd parity, push 0xFF → parity bit 1; frame 176 cycles. Same test with 0xFE → parity 0.
4. While a frame is in progress, push 5 words on consecutive cycles → first 4 accepted; data_ready=0 after the 4th; overflow pulses for one cycle on the 5th; fifo_count=4. Five frames total are sent with no high gap between stop and next start.
5. Assert rstn low mid DATA with 2 words queued → tx=1, tx_busy=0, fifo_count=0 without waiting for clk. After release, tx stays high until a new push.
6. Change cfg_parity from none to even mid-frame with 2 words queued → current frame has no parity bit; next frame includes the correct even parity bit.
